b_priority_encoder: RTL and testbench

- Registered 8-to-3 priority encoder; d[7] has the highest priority and d[0] the lowest.
- Reports the index of the highest set input bit, a valid flag, a one-hot grant vector and a multiple-request flag.
- All outputs are registered, one cycle after sampling.
- Used as a request arbiter/index generator wherever a set of request lines must be reduced to a single index.

---
 rtl/b_priority_encoder.sv | 54 +++++
 tb/tb_b_priority_encoder.sv | 124 ++++++++++++
 2 files changed

// File: rtl/b_priority_encoder.sv
// Registered priority encoder: reduces a request vector to the index of its
// highest set bit, plus valid, one-hot grant and multiple-request flags.
module b_priority_encoder #(
   parameter int WIDTH = 8,
   parameter int IDX_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [IDX_W-1:0] q,
   output logic             valid,
   output logic [WIDTH-1:0] grant,
   output logic             multi
);

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [IDX_W-1:0] idx_next;
   logic [WIDTH-1:0] grant_next;
   logic [WIDTH-1:0] d_less;
   logic             any_next;
   logic             multi_next;

   // Ascending scan, so the last (highest) set bit found wins.
   always_comb begin
      idx_next = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (d[i]) begin
            idx_next = i[IDX_W-1:0];
         end
      end
   end

   // Clearing the lowest set bit leaves something only if two or more were set.
   assign d_less     = d - ONE;
   assign multi_next = |(d & d_less);
   assign any_next   = |d;
   assign grant_next = any_next ? (ONE << idx_next) : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q     <= '0;
         valid <= 1'b0;
         grant <= '0;
         multi <= 1'b0;
      end else begin
         q     <= idx_next;
         valid <= any_next;
         grant <= grant_next;
         multi <= multi_next;
      end
   end

endmodule

// File: tb/tb_b_priority_encoder.sv
// Directed self-checking bench for b_priority_encoder: reset, exhaustive sweep,
// zero-versus-bit-0, multi flag, back-to-back changes and mid-stream reset.
module tb_b_priority_encoder;

   logic       clk;
   logic       rst;
   logic [7:0] d;
   logic [2:0] q;
   logic       valid;
   logic [7:0] grant;
   logic       multi;

   int tests_run;
   int tests_failed;

   b_priority_encoder #(.WIDTH(8), .IDX_W(3)) dut (
      .clk   (clk),
      .rst   (rst),
      .d     (d),
      .q     (q),
      .valid (valid),
      .grant (grant),
      .multi (multi)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      tests_run++;
      assert (observed === expected) else begin
         tests_failed++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic check_all(input string tag, input logic [2:0] eq, input logic ev,
                            input logic [7:0] eg, input logic em);
      check_output({tag, ".q"}, {29'd0, q}, {29'd0, eq});
      check_output({tag, ".valid"}, {31'd0, valid}, {31'd0, ev});
      check_output({tag, ".grant"}, {24'd0, grant}, {24'd0, eg});
      check_output({tag, ".multi"}, {31'd0, multi}, {31'd0, em});
   endtask

   // Change d away from the active edge, then look just after the next edge.
   task automatic apply_stimulus(input logic [7:0] val);
      @(negedge clk);
      d = val;
      @(posedge clk);
      #1;
   endtask

   // Independent reference: scan downward from the top bit.
   function automatic logic [2:0] ref_q(input logic [7:0] v);
      for (int i = 7; i >= 0; i--) begin
         if (v[i]) return 3'(i);
      end
      return 3'd0;
   endfunction

   initial begin
      logic [2:0] mq;
      logic       mv;
      tests_run    = 0;
      tests_failed = 0;
      rst = 1'b1;
      d   = 8'hFF;

      #1;
      check_all("reset_t0", 3'd0, 1'b0, 8'h00, 1'b0);
      @(posedge clk); #1;
      check_all("reset_edge1", 3'd0, 1'b0, 8'h00, 1'b0);
      @(posedge clk); #1;
      check_all("reset_edge2", 3'd0, 1'b0, 8'h00, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      check_all("reset_release", 3'd7, 1'b1, 8'h80, 1'b1);

      for (int v = 0; v < 256; v++) begin
         apply_stimulus(v[7:0]);
         mq = ref_q(v[7:0]);
         mv = (v != 0);
         check_all($sformatf("sweep_%0d", v), mq, mv, mv ? (8'h01 << mq) : 8'h00,
                   $countones(v[7:0]) >= 2);
      end

      apply_stimulus(8'h01); check_output("spot_d1.q", {29'd0, q}, 32'd0);
      apply_stimulus(8'h02); check_output("spot_d2.q", {29'd0, q}, 32'd1);
      apply_stimulus(8'h03); check_output("spot_d3.q", {29'd0, q}, 32'd1);
      apply_stimulus(8'h06); check_output("spot_d6.q", {29'd0, q}, 32'd2);
      apply_stimulus(8'hA6); check_output("spot_dA6.q", {29'd0, q}, 32'd7);

      apply_stimulus(8'h00); check_all("zero", 3'd0, 1'b0, 8'h00, 1'b0);
      apply_stimulus(8'h01); check_all("bit0", 3'd0, 1'b1, 8'h01, 1'b0);

      apply_stimulus(8'h10); check_all("multi_10", 3'd4, 1'b1, 8'h10, 1'b0);
      apply_stimulus(8'h11); check_all("multi_11", 3'd4, 1'b1, 8'h10, 1'b1);
      apply_stimulus(8'hC0); check_all("multi_C0", 3'd7, 1'b1, 8'h80, 1'b1);

      apply_stimulus(8'h80); check_all("b2b_80", 3'd7, 1'b1, 8'h80, 1'b0);
      apply_stimulus(8'h01); check_all("b2b_01", 3'd0, 1'b1, 8'h01, 1'b0);
      apply_stimulus(8'h00); check_all("b2b_00", 3'd0, 1'b0, 8'h00, 1'b0);
      apply_stimulus(8'h24); check_all("b2b_24", 3'd5, 1'b1, 8'h20, 1'b1);

      apply_stimulus(8'h80);
      check_all("pre_async", 3'd7, 1'b1, 8'h80, 1'b0);
      #2;
      rst = 1'b1;
      d   = 8'h08;
      #1;
      check_all("async_clear", 3'd0, 1'b0, 8'h00, 1'b0);
      @(posedge clk); #1;
      check_all("async_hold", 3'd0, 1'b0, 8'h00, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      check_all("async_release", 3'd3, 1'b1, 8'h08, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
